// File: rtl/seq_divider.sv
// Multi-cycle signed restoring divider: one quotient bit per cycle, sign fix-up, one-cycle done.
// Truncating division; the remainder takes the dividend's sign, and x/0 gives all ones with a flag.
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StIter, StFix, StDone} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic             r_sign_q;
  logic             r_sign_r;
  logic [CW-1:0]    r_count;

  logic [WIDTH:0]   w_a_sh;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_dvd_abs;
  logic [WIDTH-1:0] w_dvs_abs;
  logic             w_dvs_zero;

  // A is always below M (at most 2^(WIDTH-1)), so the shifted value and difference fit WIDTH+1 bits.
  assign w_a_sh     = {r_a, r_q[WIDTH-1]};
  assign w_diff     = w_a_sh - {1'b0, r_m};
  assign w_dvd_abs  = i_dividend[WIDTH-1] ? -i_dividend : i_dividend;
  assign w_dvs_abs  = i_divisor[WIDTH-1] ? -i_divisor : i_divisor;
  assign w_dvs_zero = (i_divisor == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StIdle;
      r_a           <= '0;
      r_q           <= '0;
      r_m           <= '0;
      r_sign_q      <= 1'b0;
      r_sign_r      <= 1'b0;
      r_count       <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_quotient    <= '0;
      o_remainder   <= '0;
      o_div_by_zero <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_m      <= w_dvs_abs;
            r_a      <= '0;
            r_sign_q <= i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
            r_sign_r <= i_dividend[WIDTH-1];
            r_count  <= '0;
            o_busy   <= 1'b1;
            if (w_dvs_zero) begin
              // Keep the raw dividend so it can be returned unchanged as the remainder.
              r_q     <= i_dividend;
              r_state <= StDone;
            end else begin
              r_q     <= w_dvd_abs;
              r_state <= StIter;
            end
          end
        end
        StIter: begin
          if (!w_diff[WIDTH]) begin
            r_a <= w_diff[WIDTH-1:0];
            r_q <= {r_q[WIDTH-2:0], 1'b1};
          end else begin
            r_a <= w_a_sh[WIDTH-1:0];
            r_q <= {r_q[WIDTH-2:0], 1'b0};
          end
          r_count <= r_count + CW'(1);
          if (r_count == LastCnt) begin
            r_state <= StFix;
          end
        end
        StFix: begin
          o_quotient    <= r_sign_q ? -r_q : r_q;
          o_remainder   <= r_sign_r ? -r_a : r_a;
          o_div_by_zero <= 1'b0;
          o_done        <= 1'b1;
          r_state       <= StDone;
        end
        StDone: begin
          // Entered with done low only on the divide-by-zero shortcut; publish results first.
          if (o_done) begin
            o_done  <= 1'b0;
            o_busy  <= 1'b0;
            r_state <= StIdle;
          end else begin
            o_quotient    <= '1;
            o_remainder   <= r_q;
            o_div_by_zero <= 1'b1;
            o_done        <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle signed 32-bit restoring divider for the CPU datapath's DIV operation. It sits behind the ALU's DIV opcode and answers the control sequencer's DIV request. Operand A is the dividend from Y and operand B is the divisor from the bus. It returns the quotient for ZLow and the remainder for ZHigh, then raises a one-cycle done pulse so the sequencer can advance to the ZLowout/LOin and ZHighout/HIin steps.

## Interface
- WIDTH, 32, operand/result width; the counter is sized to hold WIDTH
- Clock  in  1  system clock, rising-edge
- Clear  in  1  asynchronous, active-low reset
- start  in  1  request pulse; sampled only in IDLE
- dividend  in  WIDTH  signed dividend (Y register)
- divisor  in  WIDTH  signed divisor (bus)
- busy  out  1  high from the accepting edge until done deasserts
- done  out  1  one-cycle completion pulse
- quotient  out  WIDTH  signed quotient, to ZLow
- remainder  out  WIDTH  signed remainder, to ZHigh
- div_by_zero  out  1  divisor was zero for the last accepted request

## Operation
- States: IDLE, ITER, FIX, DONE.
- IDLE + start=1:
  - Capture |dividend| into the Q shift register and |divisor| into M.
  - Clear the partial remainder A; record sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend); set count=0.
  - Go to ITER. If divisor==0, go to DONE directly instead.
- ITER, one restoring step per cycle:
  - Shift {A,Q} left by 1 and compute A-M at WIDTH+1 bits.
  - If the difference is non-negative, A gets the difference and Q[0]=1; otherwise A is kept and Q[0]=0.
  - count++. After WIDTH steps, go to FIX.
- FIX:
  - quotient = sign_q ? -Q : Q; remainder = sign_r ? -A : A (truncating division; remainder takes the dividend's sign).
  - Go to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- Divide by zero: quotient = all ones, remainder = dividend unchanged, div_by_zero=1. Any other accepted request clears div_by_zero.
- Overflow: -2^(WIDTH-1) / -1 gives quotient 0x80000000 and remainder 0 (natural wrap), with no flag.
- Absolute values use two's-complement negate. |0x80000000| is 0x80000000 treated as unsigned, which is correct within the WIDTH+1 subtract.
- start while busy is ignored; no queuing.
- quotient, remainder and div_by_zero hold their values from the last completion until the next completion. Inputs may change freely after the accepting edge.

## Timing
- Reset (Clear=0, asynchronous): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, count=0, internal registers 0.
- Reset mid-operation aborts immediately. No done pulse is produced. Operation resumes on the first rising edge after Clear=1.
- Let edge k be the edge that accepts start:
  - busy is high from after edge k.
  - Edges k+1 through k+WIDTH perform the iterations.
  - Edge k+WIDTH+1 executes FIX: results become valid and done goes high.
  - Edge k+WIDTH+2 drops done and busy and returns to IDLE.
- Latency with WIDTH=32: results and done are visible after edge k+33.
- Divide by zero: results and done are visible after edge k+1; busy drops at edge k+2.
- busy is a registered output and goes low on the same edge as done.
- A new start can be accepted on the edge after done falls. A start asserted while done=1 is ignored.

## Test plan
- 7 / 3 (0x00000007, 0x00000003): after edge k+33, quotient=0x00000002, remainder=0x00000001, done pulses for exactly 1 cycle, busy is high for 34 cycles.
- -7 / 3 (0xFFFFFFF9, 0x00000003): quotient=0xFFFFFFFE, remainder=0xFFFFFFFF. Also 39 / -7 (0x27, 0xFFFFFFF9): quotient=0xFFFFFFFB, remainder=0x00000004.
- 0x27 / 0: done after edge k+1, quotient=0xFFFFFFFF, remainder=0x00000027, div_by_zero=1. A following 0x27 / 3 gives quotient=0x0000000D, remainder=0, div_by_zero=0.
- 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0, div_by_zero=0. Also 0x80000000 / 1: quotient=0x80000000, remainder=0.
- Start 100 / 7, then pulse Clear low at iteration 10 asynchronously between edges: all outputs read 0 within the same cycle and no done pulse follows. Restart with 100 / 7 after release: quotient=0x0000000E, remainder=0x00000002.
- Start 100 / 7, then assert start again with 5 / 1 at iteration 5 and during the done cycle: both extra starts are ignored, the result is quotient=14, remainder=2, and exactly one done pulse occurs.
